// File: rtl/spi_inert_serf.sv
// spi_inert_serf: clk-oversampled SPI responder emulating the inertial sensor's WHO_AM_I, INT config and pitch registers.
module spi_inert_serf #(
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] smpl_data,
  output logic [7:0]  int_cfg,
  output logic        frm_done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
  logic sclk_dly_q, ss_dly_q;
  logic [4:0] cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d, hold_q, hold_d, pend_q, pend_d;
  logic [7:0] tx_q, tx_d, cfg_q, cfg_d, rd_byte;
  logic miso_q, miso_d, int_q, int_d, done_q, done_d, pend_vld_q, pend_vld_d;
  logic sclk_s, ss_s, mosi_s, rise, fall, ss_fall, ss_rise, cap, full;
  logic [7:0] cmd;
  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign ss_s    = ss_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_dly_q;
  assign fall    = ~sclk_s & sclk_dly_q;
  assign ss_fall = ~ss_s & ss_dly_q;
  assign ss_rise = ss_s & ~ss_dly_q;
  assign cmd     = {shift_q[6:0], mosi_s};
  assign cap     = smpl_vld & cfg_q[1];
  assign full    = cnt_q == 5'd16;
  assign rd_byte = cmd[6:0] == 7'h0F ? WHO_AM_I_VAL :
                   cmd[6:0] == 7'h0D ? cfg_q :
                   cmd[6:0] == 7'h22 ? hold_q[7:0] :
                   cmd[6:0] == 7'h23 ? hold_q[15:8] : 8'h00;
  assign MISO     = miso_q;
  assign INT      = int_q;
  assign int_cfg  = cfg_q;
  assign frm_done = done_q;
  always_comb begin
    sclk_d     = {sclk_q[SYNC_STAGES-2:0], SCLK};
    ss_d       = {ss_q[SYNC_STAGES-2:0], SS_n};
    mosi_d     = {mosi_q[SYNC_STAGES-2:0], MOSI};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    int_d      = int_q;
    cfg_d      = cfg_q;
    done_d     = 1'b0;
    hold_d     = hold_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      IDLE: if (ss_fall) begin
        state_d = SHIFT;
        cnt_d   = '0;
        shift_d = '0;
        tx_d    = '0;
        miso_d  = 1'b0;
      end
      SHIFT: begin
        if (rise) begin
          shift_d = {shift_q[14:0], mosi_s};
          cnt_d   = cnt_q + {4'd0, cnt_q != 5'd31};
          if (cnt_q == 5'd7) tx_d = cmd[7] ? rd_byte : 8'h00;
        end
        if (fall) begin
          miso_d = cnt_q >= 5'd8 ? tx_q[7] : 1'b0;
          if (cnt_q >= 5'd8) tx_d = {tx_q[6:0], 1'b0};
        end
        if (ss_rise) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        miso_d  = 1'b0;
        done_d  = full;
        if (full && !shift_q[15] && shift_q[14:8] == 7'h0D) cfg_d = shift_q[7:0];
        if (full && shift_q[15] && shift_q[14:8] == 7'h23) int_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // samples arriving mid-frame are parked so pitch L/H stay coherent within a frame
    if (cap && state_q == IDLE) begin
      hold_d     = smpl_data;
      int_d      = 1'b1;
      pend_vld_d = 1'b0;
    end else if (cap) begin
      pend_d     = smpl_data;
      pend_vld_d = 1'b1;
    end else if (pend_vld_q && state_q != SHIFT) begin
      hold_d     = pend_q;
      int_d      = 1'b1;
      pend_vld_d = 1'b0;
    end
  end
  // SS_n chain resets low so a frame already in progress at reset release is never entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q     <= '1;
      ss_q       <= '0;
      mosi_q     <= '0;
      sclk_dly_q <= 1'b1;
      ss_dly_q   <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      int_q      <= 1'b0;
      cfg_q      <= '0;
      done_q     <= 1'b0;
      hold_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      sclk_dly_q <= sclk_s;
      ss_dly_q   <= ss_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      int_q      <= int_d;
      cfg_q      <= cfg_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
endmodule

// File: tb/tb_spi_inert_serf.sv
// tb_spi_inert_serf: drives SPI frames and sample strobes, checking against a register-level model.
module tb_spi_inert_serf;
  logic clk = 1'b0;
  logic rst_n, SS_n, SCLK, MOSI, MISO, INT, smpl_vld, frm_done;
  logic [15:0] smpl_data;
  logic [7:0] int_cfg;
  logic [7:0] m_cfg;
  logic [15:0] m_hold, m_pend;
  logic m_int, m_pv;
  int checks = 0, failures = 0, done_cnt = 0;
  logic [7:0] rb;

  spi_inert_serf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .INT(INT), .smpl_vld(smpl_vld), .smpl_data(smpl_data), .int_cfg(int_cfg), .frm_done(frm_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (frm_done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [6:0] a);
    case (a)
      7'h0F: return 8'h6A;
      7'h0D: return m_cfg;
      7'h22: return m_hold[7:0];
      7'h23: return m_hold[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_cfg = 8'h00; m_hold = 16'h0000; m_pend = 16'h0000; m_int = 1'b0; m_pv = 1'b0;
  endtask

  task automatic m_sample(input logic [15:0] d, input bit busy);
    if (m_cfg[1]) begin
      if (busy) begin m_pend = d; m_pv = 1'b1; end
      else begin m_hold = d; m_int = 1'b1; end
    end
  endtask

  task automatic do_frame(input logic [15:0] cmd, input int nbits, input int sbit,
                          input logic [15:0] sdata, output logic [7:0] rbyte);
    logic [15:0] rd;
    logic [7:0] exp;
    int d0, half;
    rd = '0;
    exp = m_rd(cmd[14:8]);
    d0 = done_cnt;
    half = $urandom_range(8, 16);
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      if (i == sbit) begin
        smpl_data = sdata; smpl_vld = 1'b1;
        @(negedge clk);
        smpl_vld = 1'b0;
        m_sample(sdata, 1'b1);
        repeat (half - 1) @(negedge clk);
      end else repeat (half) @(negedge clk);
      SCLK = 1'b1;
      rd = {rd[14:0], MISO};
      repeat (half) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    if (nbits == 16) begin
      if (!cmd[15] && cmd[14:8] == 7'h0D) m_cfg = cmd[7:0];
      if (cmd[15] && cmd[14:8] == 7'h23) m_int = 1'b0;
      check(cmd[15] ? "rd_data" : "wr_miso", rd, cmd[15] ? {8'h00, exp} : 16'h0000);
    end
    if (m_pv) begin m_hold = m_pend; m_int = 1'b1; m_pv = 1'b0; end
    check("frm_done", done_cnt - d0, (nbits == 16) ? 1 : 0);
    check("int", INT, m_int);
    check("int_cfg", int_cfg, m_cfg);
    check("miso_idle", MISO, 0);
    rbyte = rd[7:0];
  endtask

  task automatic idle_smpl(input logic [15:0] d);
    smpl_data = d; smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    m_sample(d, 1'b0);
    @(negedge clk);
    check("int_smpl", INT, m_int);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {MISO, INT, int_cfg, frm_done}, 0);
    rst_n = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0;
    SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; smpl_vld = 1'b0; smpl_data = '0;
    m_reset();
    do_reset();
    do_frame(16'h8F00, 16, -1, 0, rb); check("whoami", rb, 8'h6A);
    do_frame(16'h0D02, 16, -1, 0, rb);
    do_frame(16'h8D00, 16, -1, 0, rb); check("cfg_rd", rb, 8'h02);
    idle_smpl(16'h5663); check("int_set", INT, 1);
    do_frame(16'hA200, 16, -1, 0, rb); check("pitch_l", rb, 8'h63); check("int_kept", INT, 1);
    do_frame(16'hA300, 16, -1, 0, rb); check("pitch_h", rb, 8'h56); check("int_clr", INT, 0);
    do_frame(16'h0D00, 16, -1, 0, rb);
    idle_smpl(16'hCD0D); check("int_masked", INT, 0);
    do_frame(16'hA200, 16, -1, 0, rb); check("hold_old", rb, 8'h63);
    do_frame(16'h0D02, 16, -1, 0, rb);
    do_frame(16'hA200, 16, 4, 16'hCD0D, rb); check("coherent", rb, 8'h63); check("int_pend", INT, 1);
    do_frame(16'hA200, 16, -1, 0, rb); check("pend_l", rb, 8'h0D);
    do_frame(16'hA300, 16, -1, 0, rb); check("pend_h", rb, 8'hCD);
    do_frame(16'h0DFF, 9, -1, 0, rb); check("abort_cfg", int_cfg, 8'h02);
    d0 = done_cnt;
    SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 5) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid", {MISO, INT, int_cfg, frm_done}, 0);
        rst_n = 1'b1;
        m_reset();
      end
      SCLK = 1'b0; MOSI = i[0];
      repeat (10) @(negedge clk);
      SCLK = 1'b1;
      check("miso_ignored", MISO, 0);
      repeat (10) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_done_ignored", done_cnt - d0, 0);
    check("cfg_ignored", int_cfg, 8'h00);
    do_frame(16'h8F00, 16, -1, 0, rb); check("whoami_rst", rb, 8'h6A);
    for (int n = 0; n < 60; n++) begin
      logic [6:0] a;
      logic [15:0] c;
      int nb, sb;
      if ($urandom_range(0, 3) == 0) idle_smpl(16'($urandom));
      else begin
        case ($urandom_range(0, 4))
          0: a = 7'h0F;
          1: a = 7'h0D;
          2: a = 7'h22;
          3: a = 7'h23;
          default: a = 7'($urandom);
        endcase
        c = {1'($urandom_range(0, 1)), a, 8'($urandom)};
        nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 16;
        sb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
        do_frame(c, nb, sb, 16'($urandom), rb);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_inert_serf.md
Name: spi_inert_serf

Overview:
- Synthesizable SPI responder (serf) for the far end of a SPI_mnrch link.
- Emulates the subset of the inertial sensor register map the Segway firmware uses: WHO_AM_I, INT config, and pitch low/high registers fed from a parallel sample port.
- Drives a data-ready INT line.
- Runs entirely on the system clock and oversamples SCLK, SS_n and MOSI. This allows it to sit in FPGA bring-up builds and full-chip benches in place of the behavioural sensor model.

Parameters:
- WHO_AM_I_VAL, 8'h6A, value returned by register 0x0F.
- SYNC_STAGES, 2, flop stages on SCLK/SS_n/MOSI before edge detection (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  active-low frame select from monarch
- SCLK  in  1  serial clock from monarch (idles high)
- MOSI  in  1  serial data from monarch
- MISO  out  1  serial data to monarch
- INT  out  1  data-ready interrupt, active high
- smpl_vld  in  1  one-clk strobe: new pitch sample available
- smpl_data  in  16  pitch sample, two's complement
- int_cfg  out  8  current value of register 0x0D
- frm_done  out  1  one-clk pulse after each valid 16-bit frame completes

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: MISO=0, INT=0, int_cfg=8'h00, frm_done=0, holding register=16'h0000, bit counter=0, shift register=0.
- Input synchronization:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - Rise and fall are detected on the synchronized SCLK by comparing with a delayed copy.
  - Synchronized SCLK high and low phases are guaranteed at least 6 clk each; the standard monarch gives 16.
- Frame format, 16 bits, MSB first:
  - bit15: R/W (1 = read).
  - bits14:8: address.
  - bits7:0: write data (write frames) or don't-care (read frames).
- Sampling edges:
  - MOSI is sampled on synchronized SCLK rise.
  - MISO changes on synchronized SCLK fall, 1 clk after fall detect.
- States:
  - IDLE → SHIFT when synchronized SS_n falls: clear bit counter and shift register.
  - SHIFT: each SCLK rise shifts MOSI into shift[0] and increments the counter.
  - At count 8 the command is decoded. For a read, the read byte is latched into the MISO shift register; that register's MSB drives MISO on the 8th fall, and it shifts one bit per subsequent fall.
  - Before count 8, MISO=0.
  - SHIFT → DONE on synchronized SS_n rise.
  - DONE (1 clk): if count==16, commit the write, perform the INT clear, and pulse frm_done. Then return to IDLE.
  - Any other count is an aborted frame: no write, no INT clear, no frm_done.
- MISO is driven 0 whenever SS_n is high.
- Read map:
  - 0x0F → WHO_AM_I_VAL.
  - 0x0D → int_cfg.
  - 0x22 → holding[7:0].
  - 0x23 → holding[15:8].
  - All other addresses → 8'h00.
- Write map: only 0x0D is writable (int_cfg ← data byte). Writes elsewhere are ignored but still pulse frm_done.
- Sample capture:
  - If smpl_vld and int_cfg[1], holding ← smpl_data and INT ← 1 on the next clk.
  - If int_cfg[1]=0, smpl_vld is ignored.
  - If smpl_vld arrives while not IDLE, the sample is held in a pending buffer and applied in the DONE/IDLE cycle. Pitch L/H therefore stay coherent within a frame.
  - A newer pending sample overwrites an older one.
- INT clear: a completed read of 0x23 clears INT in DONE.
  - If a pending sample is applied in the same cycle, INT stays 1 and holding takes the new value.
- Writing int_cfg[1]=0 does not clear INT or holding.
- Asserting rst_n low mid-frame returns to the reset state immediately. Monarch activity is ignored until SS_n is next seen high, then falls.

Test Plan:
- Reset, frame 16'h8F00 → monarch rd_data[7:0]=8'h6A; frm_done pulses once; INT=0.
- Frame 16'h0D02, then 16'h8D00 → int_cfg=8'h02; readback rd_data[7:0]=8'h02.
- With int_cfg=02, smpl_data=16'h5663 with smpl_vld → INT=1 within 2 clk. Then 16'hA200 → 8'h63 with INT still 1; 16'hA300 → 8'h56 with INT=0 after the frame.
- With int_cfg=00, smpl_vld with smpl_data=16'hCD0D → INT stays 0; 16'hA200 returns the old holding byte.
- smpl_data=16'hCD0D strobed during an A200 frame (int_cfg=02) → that frame returns the old low byte; after the frame, INT=1, A200 → 8'h0D, A300 → 8'hCD.
- SS_n raised after 9 SCLKs of 16'h0DFF → int_cfg unchanged, no frm_done. rst_n pulsed mid-frame → all outputs at reset values, and the next full 8F00 frame returns 8'h6A.
